gp_dma_prog: RTL and testbench

Descriptor-driven cbus initiator that programs one gp_dma channel through its 4-bit-address register port. It takes queued transfer descriptors, polls the channel's CTRL register until idle, then writes SRC_ADDR, DEST_ADDR and CTRL (with the go bit set). It waits for the channel's done_intr pulse and reports a completion status. It sits between a sequencer/CPU-side descriptor source and the gp_dma register slave, on the same cbus_clk domain.

---
 rtl/gp_dma_prog_if.sv | 38 +++
 rtl/gp_dma_prog.sv | 257 +++++++++++++++++++++++++
 tb/tb_gp_dma_prog.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_dma_prog_if.sv
// gp_dma_prog_if: cbus register-access bundle between the gp_dma_prog
// initiator (master) and the gp_dma channel register slave.
//   master_cbus_req      single-cycle access strobe
//   master_cbus_cmd      1 = read, 0 = write
//   master_cbus_address  register index (0 SRC_ADDR, 1 DEST_ADDR, 2 CTRL)
//   master_cbus_wdata    write data
//   master_cbus_byten    byte enables
//   master_cbus_rdata    read data, valid in the same cycle as req
//   master_cbus_aerror   address error, valid in the same cycle as req
interface gp_dma_prog_if;
  logic        master_cbus_req;
  logic        master_cbus_cmd;
  logic [3:0]  master_cbus_address;
  logic [31:0] master_cbus_wdata;
  logic [3:0]  master_cbus_byten;
  logic [31:0] master_cbus_rdata;
  logic        master_cbus_aerror;

  modport master (
    output master_cbus_req,
    output master_cbus_cmd,
    output master_cbus_address,
    output master_cbus_wdata,
    output master_cbus_byten,
    input  master_cbus_rdata,
    input  master_cbus_aerror
  );

  modport slave (
    input  master_cbus_req,
    input  master_cbus_cmd,
    input  master_cbus_address,
    input  master_cbus_wdata,
    input  master_cbus_byten,
    output master_cbus_rdata,
    output master_cbus_aerror
  );
endinterface

// File: rtl/gp_dma_prog.sv
// gp_dma_prog: descriptor-driven cbus initiator that programs one gp_dma
// channel. Descriptors are queued, the channel CTRL register is polled until
// neither pending nor active, then SRC_ADDR, DEST_ADDR and CTRL (go bit set)
// are written. Completion (ok / zero-length / address error / timeout) is
// reported with a one-cycle cpl_valid pulse.
// Ports:
//   cbus_clk, cbus_rst     clock, synchronous active-high reset
//   desc_*                 descriptor valid/ready handshake and fields
//   cbus                   cbus register access bundle (master side)
//   done_intr              one-cycle completion pulse from the channel
//   cpl_valid, cpl_status  completion pulse and status
//   busy                   queue non-empty or sequencer not idle
module gp_dma_prog #(
  parameter int FIFO_DEPTH     = 4,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 cbus_clk,
  input  logic                 cbus_rst,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [31:0]          desc_src,
  input  logic [31:0]          desc_dst,
  input  logic [17:0]          desc_byte_count,
  input  logic [1:0]           desc_burst,
  input  logic [1:0]           desc_src_amode,
  input  logic [1:0]           desc_dst_amode,
  input  logic [2:0]           desc_pri,
  gp_dma_prog_if.master        cbus,
  input  logic                 done_intr,
  output logic                 cpl_valid,
  output logic [1:0]           cpl_status,
  output logic                 busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_AERR = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  localparam logic [3:0] ADDR_SRC  = 4'd0;
  localparam logic [3:0] ADDR_DST  = 4'd1;
  localparam logic [3:0] ADDR_CTRL = 4'd2;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [17:0] byte_count;
    logic [1:0]  burst;
    logic [1:0]  src_amode;
    logic [1:0]  dst_amode;
    logic [2:0]  pri;
  } desc_t;

  typedef enum logic [3:0] {
    IDLE, POLL, POLL_WAIT, WR_SRC, WR_DST, WR_CTRL, WAIT_DONE, ABORT, CPL
  } state_t;

  // Descriptor queue
  desc_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fifo_full, fifo_empty, push, pop;
  desc_t            desc_in, head, work_reg;

  state_t           state_reg, state_next;
  logic [1:0]       status_next;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             tmo_hit, gap_done;
  logic [31:0]      ctrl_word;

  assign desc_in    = {desc_src, desc_dst, desc_byte_count, desc_burst,
                       desc_src_amode, desc_dst_amode, desc_pri};
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign desc_ready = !fifo_full && !cbus_rst;
  assign push       = desc_valid && desc_ready;
  assign pop        = (state_reg == IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_reg];
  assign busy       = !fifo_empty || (state_reg != IDLE);

  // "Reached" means this is the TIMEOUT_CYCLES-th counted cycle.
  assign tmo_hit  = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
  assign gap_done = (gap_cnt_reg == GAP_W'(POLL_GAP - 1));

  assign ctrl_word = {1'b1, 2'b00, work_reg.pri, work_reg.dst_amode,
                      work_reg.src_amode, work_reg.burst, 2'b00,
                      work_reg.byte_count};

  // Storage has no reset; only pointers and count are cleared, which flushes.
  always_ff @(posedge cbus_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= desc_in;
  end

  always_ff @(posedge cbus_clk) begin
    if (cbus_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Next state. An address error on any access ends the descriptor at once;
  // in WAIT_DONE a done pulse takes priority over a coincident timeout.
  always_comb begin
    state_next  = state_reg;
    status_next = ST_OK;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          if (head.byte_count == '0) begin
            state_next  = CPL;
            status_next = ST_ZERO;
          end else begin
            state_next = POLL;
          end
        end
      end
      POLL: begin
        if (cbus.master_cbus_aerror) begin
          state_next  = CPL;
          status_next = ST_AERR;
        end else if (tmo_hit) begin
          state_next  = CPL;
          status_next = ST_TMO;
        end else if (cbus.master_cbus_rdata[31] || cbus.master_cbus_rdata[30]) begin
          state_next = POLL_WAIT;
        end else begin
          state_next = WR_SRC;
        end
      end
      POLL_WAIT: begin
        if (tmo_hit) begin
          state_next  = CPL;
          status_next = ST_TMO;
        end else if (gap_done) begin
          state_next = POLL;
        end
      end
      WR_SRC, WR_DST, WR_CTRL: begin
        if (cbus.master_cbus_aerror) begin
          state_next  = CPL;
          status_next = ST_AERR;
        end else if (state_reg == WR_SRC) begin
          state_next = WR_DST;
        end else if (state_reg == WR_DST) begin
          state_next = WR_CTRL;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_intr) begin
          state_next  = CPL;
          status_next = ST_OK;
        end else if (tmo_hit) begin
          state_next = ABORT;
        end
      end
      ABORT: begin
        state_next  = CPL;
        status_next = cbus.master_cbus_aerror ? ST_AERR : ST_TMO;
      end
      CPL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cbus_clk) begin
    if (cbus_rst) begin
      state_reg   <= IDLE;
      work_reg    <= '0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) work_reg <= head;
      // One counter serves both the polling phase and the done wait.
      if (state_reg == IDLE || state_reg == WR_CTRL) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == POLL || state_reg == POLL_WAIT ||
                   state_reg == WAIT_DONE) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      gap_cnt_reg <= (state_reg == POLL_WAIT) ? gap_cnt_reg + 1'b1 : '0;
    end
  end

  // Bus and completion outputs are registered from the next state so they
  // line up with the state they belong to; idle fields are forced to 0.
  always_ff @(posedge cbus_clk) begin
    if (cbus_rst) begin
      cbus.master_cbus_req     <= 1'b0;
      cbus.master_cbus_cmd     <= 1'b0;
      cbus.master_cbus_address <= '0;
      cbus.master_cbus_wdata   <= '0;
      cbus.master_cbus_byten   <= '0;
      cpl_valid                <= 1'b0;
      cpl_status               <= ST_OK;
    end else begin
      cbus.master_cbus_req     <= 1'b0;
      cbus.master_cbus_cmd     <= 1'b0;
      cbus.master_cbus_address <= '0;
      cbus.master_cbus_wdata   <= '0;
      cbus.master_cbus_byten   <= '0;
      cpl_valid                <= (state_next == CPL);
      cpl_status               <= (state_next == CPL) ? status_next : ST_OK;
      case (state_next)
        POLL: begin
          cbus.master_cbus_req     <= 1'b1;
          cbus.master_cbus_cmd     <= 1'b1;
          cbus.master_cbus_address <= ADDR_CTRL;
          cbus.master_cbus_byten   <= 4'hF;
        end
        WR_SRC: begin
          cbus.master_cbus_req     <= 1'b1;
          cbus.master_cbus_address <= ADDR_SRC;
          cbus.master_cbus_wdata   <= work_reg.src;
          cbus.master_cbus_byten   <= 4'hF;
        end
        WR_DST: begin
          cbus.master_cbus_req     <= 1'b1;
          cbus.master_cbus_address <= ADDR_DST;
          cbus.master_cbus_wdata   <= work_reg.dst;
          cbus.master_cbus_byten   <= 4'hF;
        end
        WR_CTRL: begin
          cbus.master_cbus_req     <= 1'b1;
          cbus.master_cbus_address <= ADDR_CTRL;
          cbus.master_cbus_wdata   <= ctrl_word;
          cbus.master_cbus_byten   <= 4'hF;
        end
        ABORT: begin
          // Writing CTRL with all zeros clears the channel's pending bit.
          cbus.master_cbus_req     <= 1'b1;
          cbus.master_cbus_address <= ADDR_CTRL;
          cbus.master_cbus_byten   <= 4'hF;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gp_dma_prog.sv
// tb_gp_dma_prog: directed test of gp_dma_prog. Stimulus pushes expected bus
// accesses and completions into queues; a negedge monitor pops and compares
// whenever the DUT drives req or cpl_valid.
`timescale 1ns/1ps
module tb_gp_dma_prog;
  logic        cbus_clk = 1'b0;
  always #5 cbus_clk = ~cbus_clk;

  logic        cbus_rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_src;
  logic [31:0] desc_dst;
  logic [17:0] desc_byte_count;
  logic [1:0]  desc_burst;
  logic [1:0]  desc_src_amode;
  logic [1:0]  desc_dst_amode;
  logic [2:0]  desc_pri;
  logic        done_intr;
  logic        cpl_valid;
  logic [1:0]  cpl_status;
  logic        busy;

  gp_dma_prog_if bus();

  gp_dma_prog #(.FIFO_DEPTH(4), .POLL_GAP(2), .TIMEOUT_CYCLES(16)) dut (
    .cbus_clk        (cbus_clk),
    .cbus_rst        (cbus_rst),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_src        (desc_src),
    .desc_dst        (desc_dst),
    .desc_byte_count (desc_byte_count),
    .desc_burst      (desc_burst),
    .desc_src_amode  (desc_src_amode),
    .desc_dst_amode  (desc_dst_amode),
    .desc_pri        (desc_pri),
    .cbus            (bus),
    .done_intr       (done_intr),
    .cpl_valid       (cpl_valid),
    .cpl_status      (cpl_status),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int poll_cnt = 0;
  int busy_until = 0;
  int aerr_addr = -1;
  logic [31:0] busy_word = 32'h8000_0000;

  typedef struct {
    int          cyc;
    logic        cmd;
    logic [3:0]  addr;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] status;
  } cpl_exp_t;

  bus_exp_t bus_q[$];
  cpl_exp_t cpl_q[$];
  bus_exp_t mon_e;
  cpl_exp_t mon_c;

  // Channel model: CTRL reads busy while poll_cnt < busy_until.
  always @(posedge cbus_clk) begin
    cyc <= cyc + 1;
    if (bus.master_cbus_req && bus.master_cbus_cmd) poll_cnt <= poll_cnt + 1;
  end

  always_comb begin
    bus.master_cbus_rdata  = 32'h0;
    bus.master_cbus_aerror = 1'b0;
    if (bus.master_cbus_req) begin
      if (bus.master_cbus_cmd && poll_cnt < busy_until)
        bus.master_cbus_rdata = busy_word;
      if (!bus.master_cbus_cmd && aerr_addr >= 0 &&
          int'(bus.master_cbus_address) == aerr_addr)
        bus.master_cbus_aerror = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge cbus_clk) begin
    if (bus.master_cbus_req) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req cycle %0d: got cmd=%0d addr=%0d wdata=0x%08h expected no access",
                 cyc, bus.master_cbus_cmd, bus.master_cbus_address, bus.master_cbus_wdata);
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.cyc >= 0) chk("req_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("req_cmd", 32'(bus.master_cbus_cmd), 32'(mon_e.cmd));
        chk("req_addr", 32'(bus.master_cbus_address), 32'(mon_e.addr));
        if (!mon_e.cmd) chk("req_wdata", bus.master_cbus_wdata, mon_e.data);
        chk("req_byten", 32'(bus.master_cbus_byten), 32'h0000_000F);
      end
    end else begin
      chk("idle_fields", 32'({bus.master_cbus_cmd, bus.master_cbus_address, bus.master_cbus_byten}), 32'h0);
      chk("idle_wdata", bus.master_cbus_wdata, 32'h0);
    end
    if (cpl_valid) begin
      if (cpl_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cpl cycle %0d: got status %0d expected no completion", cyc, cpl_status);
      end else begin
        mon_c = cpl_q.pop_front();
        if (mon_c.cyc >= 0) chk("cpl_cycle", 32'(cyc), 32'(mon_c.cyc));
        chk("cpl_status", 32'(cpl_status), 32'(mon_c.status));
      end
    end
  end

  task automatic exp_bus(input int c, input logic cmd, input logic [3:0] a, input logic [31:0] d);
    bus_exp_t e;
    e.cyc = c; e.cmd = cmd; e.addr = a; e.data = d;
    bus_q.push_back(e);
  endtask

  task automatic exp_cpl(input int c, input logic [1:0] s);
    cpl_exp_t e;
    e.cyc = c; e.status = s;
    cpl_q.push_back(e);
  endtask

  // Drives a descriptor at the next negedge; t is the push cycle.
  task automatic issue(output int t, input logic [31:0] s, input logic [31:0] d,
                       input logic [17:0] bc, input logic [1:0] bu,
                       input logic [1:0] sa, input logic [1:0] da, input logic [2:0] p);
    @(negedge cbus_clk);
    t = cyc;
    desc_src = s; desc_dst = d; desc_byte_count = bc; desc_burst = bu;
    desc_src_amode = sa; desc_dst_amode = da; desc_pri = p;
    desc_valid = 1'b1;
    chk("desc_ready_on_push", 32'(desc_ready), 32'd1);
  endtask

  task automatic issue_a(output int t);
    issue(t, 32'h0000_1000, 32'h0000_2000, 18'h40, 2'd1, 2'd0, 2'd1, 3'd3);
  endtask

  task automatic issue_b(output int t);
    issue(t, 32'h3000_0004, 32'h4000_0008, 18'h3FFFF, 2'd2, 2'd1, 2'd2, 3'd7);
  endtask

  task automatic drop();
    @(negedge cbus_clk);
    desc_valid = 1'b0;
  endtask

  task automatic pulse_done(input int c);
    while (cyc < c) @(negedge cbus_clk);
    done_intr = 1'b1;
    @(negedge cbus_clk);
    done_intr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bus_q.size() != 0 || cpl_q.size() != 0) && n < 300) begin
      @(negedge cbus_clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_%s: got %0d bus and %0d cpl expectations outstanding expected 0",
               name, bus_q.size(), cpl_q.size());
    end
    repeat (3) @(negedge cbus_clk);
  endtask

  task automatic exp_prog_a(input int t0);
    exp_bus(t0 + 0, 1'b0, 4'd0, 32'h0000_1000);
    exp_bus(t0 + 1, 1'b0, 4'd1, 32'h0000_2000);
    exp_bus(t0 + 2, 1'b0, 4'd2, 32'h8D10_0040);
  endtask

  task automatic exp_prog_b(input int t0);
    exp_bus(t0 + 0, 1'b0, 4'd0, 32'h3000_0004);
    exp_bus(t0 + 1, 1'b0, 4'd1, 32'h4000_0008);
    exp_bus(t0 + 2, 1'b0, 4'd2, 32'h9E63_FFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2;
    cbus_rst = 1'b1; desc_valid = 1'b0; done_intr = 1'b0;
    desc_src = '0; desc_dst = '0; desc_byte_count = '0; desc_burst = '0;
    desc_src_amode = '0; desc_dst_amode = '0; desc_pri = '0;

    // Reset state
    repeat (3) @(negedge cbus_clk);
    chk("rst_desc_ready", 32'(desc_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("rst_cpl_status", 32'(cpl_status), 32'd0);
    cbus_rst = 1'b0;
    @(negedge cbus_clk);
    chk("post_rst_desc_ready", 32'(desc_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Basic programming sequence, channel idle
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_prog_a(t + 3);
    exp_cpl(t + 9, 2'b00);
    drop();
    chk("busy_active", 32'(busy), 32'd1);
    pulse_done(t + 8);
    drain("basic");

    // Three busy polls, spaced POLL_GAP+1; a stray done in POLL_WAIT is ignored
    busy_word = 32'h8000_0000;
    busy_until = poll_cnt + 3;
    issue_b(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 5, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 8, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 11, 1'b1, 4'd2, 32'h0);
    exp_prog_b(t + 12);
    exp_cpl(t + 18, 2'b00);
    drop();
    pulse_done(t + 4);
    pulse_done(t + 17);
    drain("poll_busy");

    // Zero-length descriptor: no bus traffic
    issue(t, 32'h0000_5000, 32'h0000_6000, 18'h0, 2'd1, 2'd0, 2'd0, 3'd1);
    exp_cpl(t + 2, 2'b01);
    drop();
    drain("zero_len");

    // Address error on the DEST_ADDR write
    aerr_addr = 1;
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 3, 1'b0, 4'd0, 32'h0000_1000);
    exp_bus(t + 4, 1'b0, 4'd1, 32'h0000_2000);
    exp_cpl(t + 5, 2'b10);
    drop();
    drain("aerror");
    aerr_addr = -1;

    // Poll timeout with the active bit held
    busy_word = 32'h4000_0000;
    busy_until = poll_cnt + 6;
    issue_a(t);
    for (int k = 0; k < 6; k++) exp_bus(t + 2 + 3 * k, 1'b1, 4'd2, 32'h0);
    exp_cpl(t + 18, 2'b11);
    drop();
    drain("poll_timeout");

    // done_intr never arrives: abort write after 16 WAIT_DONE cycles
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_prog_a(t + 3);
    exp_bus(t + 22, 1'b0, 4'd2, 32'h0000_0000);
    exp_cpl(t + 23, 2'b11);
    drop();
    drain("done_timeout");

    // done_intr on the timeout cycle wins
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_prog_a(t + 3);
    exp_cpl(t + 22, 2'b00);
    drop();
    pulse_done(t + 21);
    drain("done_on_timeout");

    // Back-to-back descriptors: next pop the cycle after CPL
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_prog_a(t + 3);
    exp_cpl(t + 8, 2'b00);
    issue_b(t2);
    chk("b2b_push_cycle", 32'(t2), 32'(t + 1));
    exp_bus(t + 10, 1'b1, 4'd2, 32'h0);
    exp_prog_b(t + 11);
    exp_cpl(t + 16, 2'b00);
    drop();
    pulse_done(t + 7);
    pulse_done(t + 15);
    drain("back_to_back");

    // Fill the queue, then reset mid-WR_DST: flush, no completion
    busy_word = 32'h8000_0000;
    busy_until = poll_cnt + 2;
    issue_a(t);
    exp_bus(t + 2, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 5, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 8, 1'b1, 4'd2, 32'h0);
    exp_bus(t + 9, 1'b0, 4'd0, 32'h0000_1000);
    exp_bus(t + 10, 1'b0, 4'd1, 32'h0000_2000);
    for (int k = 0; k < 4; k++) issue_b(t2);
    @(negedge cbus_clk);
    desc_valid = 1'b0;
    chk("full_desc_ready", 32'(desc_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    while (cyc < t + 10) @(negedge cbus_clk);
    cbus_rst = 1'b1;
    @(negedge cbus_clk);
    chk("in_rst_desc_ready", 32'(desc_ready), 32'd0);
    chk("in_rst_busy", 32'(busy), 32'd0);
    chk("in_rst_req", 32'(bus.master_cbus_req), 32'd0);
    @(negedge cbus_clk);
    cbus_rst = 1'b0;
    @(negedge cbus_clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_desc_ready", 32'(desc_ready), 32'd1);
    chk("flush_req", 32'(bus.master_cbus_req), 32'd0);
    repeat (30) @(negedge cbus_clk);
    chk("flush_busy_late", 32'(busy), 32'd0);
    drain("flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
